// File: rtl/posit_encode_seq.sv
// -----------------------------------------------------------------------------
// posit_pkg / posit_encode_seq
//
// Packs the decoded result fields of the PPU square-root stage into an N-bit
// posit. It rounds to nearest-even, saturates to maxpos/minpos and handles
// the zero and NaR special values.
//
// Flow: IDLE (accept) -> PACK (build body/guard/sticky) -> ROUND (round,
// negate, specials) -> HOLD (wait for out_ready_i). Only one operation is in
// flight at a time. The result is valid three cycles after the accept cycle.
//
// Ports:
//   clk_i        clock
//   rst_i        asynchronous, active-high reset
//   in_valid_i   input fields valid
//   in_ready_o   block can accept an input (IDLE only)
//   sign_i       result sign (1 = negative)
//   sign_exp_i   regime sign (1 = run of zeros, 0 = run of ones)
//   regime_i     regime run length, >= 1
//   exp_i        exponent field
//   mant_i       mantissa, hidden bit at 2N-1
//   zero_i       result is zero
//   nar_i        result is NaR (takes priority over zero_i)
//   out_valid_o  posit_o valid
//   out_ready_i  downstream accepts
//   posit_o      encoded posit
//   inexact_o    (only with POSIT_ENC_INEXACT_EN) guard|sticky|sat,
//                forced to 0 for the specials
//
// Optional build macro: POSIT_ENC_INEXACT_EN adds the inexact_o flag.
// -----------------------------------------------------------------------------
package posit_pkg;

  typedef enum logic [1:0] {
    POSIT32 = 2'd0,  // ES = 2
    POSIT16 = 2'd1,  // ES = 1
    POSIT64 = 2'd2   // ES = 2
  } posit_format_e;

  function automatic int posit_width(posit_format_e f);
    case (f)
      POSIT16: return 16;
      POSIT64: return 64;
      default: return 32;
    endcase
  endfunction

  function automatic int exp_bits(posit_format_e f);
    case (f)
      POSIT16: return 1;
      default: return 2;
    endcase
  endfunction

endpackage

module posit_encode_seq #(
  parameter posit_pkg::posit_format_e pFormat = posit_pkg::posit_format_e'(0),
  localparam int N  = posit_pkg::posit_width(pFormat),
  localparam int ES = posit_pkg::exp_bits(pFormat),
  localparam int RS = $clog2(N)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic            sign_i,
  input  logic            sign_exp_i,
  input  logic [RS+4:0]   regime_i,
  input  logic [ES-1:0]   exp_i,
  input  logic [2*N-1:0]  mant_i,
  input  logic            zero_i,
  input  logic            nar_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [N-1:0]    posit_o
`ifdef POSIT_ENC_INEXACT_EN
  ,
  output logic            inexact_o
`endif
);

  localparam int RW = RS + 5;          // regime counter width
  localparam int BW = N - 1;           // body width (posit without sign)
  localparam int TW = 2 * N + ES;      // terminator + exponent + fraction
  localparam int SW = 2 * N + RS + 5;  // regime shifter staging width

  typedef enum logic [1:0] {IDLE, PACK, ROUND, HOLD} state_e;

  state_e state_q, state_d;

  // Captured input fields
  logic            sign_q, se_q, zero_q, nar_q;
  logic [RW-1:0]   regime_q;
  logic [ES-1:0]   exp_q;
  logic [2*N-1:0]  mant_q;

  // PACK results
  logic [BW-1:0]   body_q;
  logic            guard_q, sticky_q, sat_q;

  // Output registers
  logic [N-1:0]    posit_q;
`ifdef POSIT_ENC_INEXACT_EN
  logic            inexact_q;
`endif

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    // NOTE: clocked state uses non-blocking assignments, so every register
    // samples values from before the edge regardless of statement order.
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    // NOTE: assigning a default first means no path leaves state_d
    // unassigned, which would otherwise infer a latch.
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid_i)  state_d = PACK;
      PACK:                     state_d = ROUND;
      ROUND:                    state_d = HOLD;
      HOLD:    if (out_ready_i) state_d = IDLE;
      default:                  state_d = IDLE;
    endcase
  end

  assign in_ready_o  = (state_q == IDLE);
  assign out_valid_o = (state_q == HOLD);
  assign posit_o     = posit_q;
`ifdef POSIT_ENC_INEXACT_EN
  assign inexact_o   = inexact_q;
`endif

  // ---------------------------------------------------------------------------
  // PACK datapath: the bit string is <regime run><terminator><exp><fraction>.
  // The tail (terminator onward) is placed at the top of the staging vector
  // and shifted right by the run length. The vacated top bits are filled with
  // the run value. Tail bits that fall off the bottom are OR-ed into sticky.
  // ---------------------------------------------------------------------------
  logic [TW-1:0]  tail;
  logic [SW-1:0]  ext, stage, fill;
  logic           lost, pk_sat, pk_guard, pk_sticky;
  logic [BW-1:0]  pk_body;

  always_comb begin
    tail  = {se_q, exp_q, mant_q[2*N-2:0]};
    ext   = {tail, {(SW-TW){1'b0}}};
    fill  = se_q ? '0 : ~({SW{1'b1}} >> regime_q);
    stage = (ext >> regime_q) | fill;
    lost  = |(ext & ~({SW{1'b1}} << regime_q));

    pk_sat = (regime_q >= RW'(N - 1));
    if (pk_sat) begin
      // Terminator and exponent do not fit: clamp to maxpos/minpos, exact body.
      pk_body   = se_q ? BW'(1) : '1;
      pk_guard  = 1'b0;
      pk_sticky = 1'b0;
    end else begin
      pk_body   = stage[SW-1 -: BW];
      pk_guard  = stage[SW-N];
      pk_sticky = (|stage[SW-N-1:0]) | lost;
    end
  end

  // ---------------------------------------------------------------------------
  // ROUND datapath
  // ---------------------------------------------------------------------------
  logic           round_up;
  logic [BW-1:0]  body_rnd;
  logic [N-1:0]   mag, rnd_posit;

  always_comb begin
    // An all-ones body is maxpos; incrementing it would wrap into NaR.
    round_up = guard_q & (sticky_q | body_q[0]) & ~(&body_q);
    body_rnd = body_q + BW'(round_up);
    // A nonzero value must never encode as zero; clamp to minpos.
    if (body_rnd == '0) body_rnd = BW'(1);
    mag = {1'b0, body_rnd};

    if (nar_q)       rnd_posit = {1'b1, {(N-1){1'b0}}};
    else if (zero_q) rnd_posit = '0;
    else if (sign_q) rnd_posit = -mag;
    else             rnd_posit = mag;
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sign_q    <= 1'b0;
      se_q      <= 1'b0;
      zero_q    <= 1'b0;
      nar_q     <= 1'b0;
      regime_q  <= '0;
      exp_q     <= '0;
      mant_q    <= '0;
      body_q    <= '0;
      guard_q   <= 1'b0;
      sticky_q  <= 1'b0;
      sat_q     <= 1'b0;
      posit_q   <= '0;
`ifdef POSIT_ENC_INEXACT_EN
      inexact_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: if (in_valid_i) begin
          sign_q   <= sign_i;
          se_q     <= sign_exp_i;
          zero_q   <= zero_i;
          nar_q    <= nar_i;
          regime_q <= regime_i;
          exp_q    <= exp_i;
          mant_q   <= mant_i;
        end
        PACK: begin
          body_q   <= pk_body;
          guard_q  <= pk_guard;
          sticky_q <= pk_sticky;
          sat_q    <= pk_sat;
        end
        ROUND: begin
          posit_q   <= rnd_posit;
`ifdef POSIT_ENC_INEXACT_EN
          inexact_q <= (nar_q | zero_q) ? 1'b0 : (guard_q | sticky_q | sat_q);
`endif
        end
        default: ;
      endcase
    end
  end

`ifndef POSIT_ENC_INEXACT_EN
  // sat_q only feeds the inexact flag; keep it visibly consumed.
  logic unused_sat;
  assign unused_sat = sat_q;
`endif

endmodule

// File: tb/tb_posit_encode_seq.sv
// -----------------------------------------------------------------------------
// tb_posit_encode_seq
//
// Self-checking bench for posit_encode_seq (posit32, ES=2). The reference
// model spells out the posit bit string as a queue of bits and then rounds
// it with plain integer arithmetic. The bench runs directed cases followed by
// random ones. It also covers the latency, a back-pressure hold and an
// asynchronous reset in the middle of an operation.
// -----------------------------------------------------------------------------
module tb_posit_encode_seq;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        in_valid_i = 1'b0;
  logic        in_ready_o;
  logic        sign_i = 1'b0;
  logic        sign_exp_i = 1'b0;
  logic [9:0]  regime_i = 10'd1;
  logic [1:0]  exp_i = 2'd0;
  logic [63:0] mant_i = 64'd0;
  logic        zero_i = 1'b0;
  logic        nar_i = 1'b0;
  logic        out_valid_o;
  logic        out_ready_i = 1'b1;
  logic [31:0] posit_o;
`ifdef POSIT_ENC_INEXACT_EN
  logic        inexact_o;
`endif

  int checks = 0;
  int errors = 0;

  posit_encode_seq dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .sign_i      (sign_i),
    .sign_exp_i  (sign_exp_i),
    .regime_i    (regime_i),
    .exp_i       (exp_i),
    .mant_i      (mant_i),
    .zero_i      (zero_i),
    .nar_i       (nar_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .posit_o     (posit_o)
`ifdef POSIT_ENC_INEXACT_EN
    ,
    .inexact_o   (inexact_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: build the bit string, cut it into body/guard/sticky, then round.
  function automatic logic [31:0] ref_posit(input bit s, input bit se, input int r,
                                            input bit [1:0] e, input bit [63:0] m,
                                            input bit z, input bit nr, output bit inex);
    bit      q[$];
    longint  body;
    bit      g, st;
    inex = 1'b0;
    if (nr) return 32'h8000_0000;
    if (z)  return 32'h0;
    if (r >= 31) begin
      inex = 1'b1;
      body = se ? 64'd1 : 64'h7FFF_FFFF;
    end else begin
      for (int i = 0; i < r; i++) q.push_back(!se);
      q.push_back(se);
      q.push_back(e[1]);
      q.push_back(e[0]);
      for (int i = 62; i >= 0; i--) q.push_back(m[i]);
      body = 0;
      for (int i = 0; i < 31; i++) body = body * 2 + longint'(q[i]);
      g  = q[31];
      st = 1'b0;
      for (int i = 32; i < q.size(); i++) st |= q[i];
      inex = g | st;
      if (g && (st || (body % 2) == 1) && body != 64'h7FFF_FFFF) body++;
      if (body == 0) body = 1;
    end
    return s ? 32'(-body) : 32'(body);
  endfunction

  // One complete transaction. hold > 0 keeps out_ready_i low for that many
  // cycles once the result is visible, pulsing in_valid_i meanwhile.
  task automatic run_op(input string tag, input bit s, input bit se, input int r,
                        input bit [1:0] e, input bit [63:0] m, input bit z,
                        input bit nr, input int hold);
    logic [31:0] exp_p;
    bit          exp_inex;
    int          lat;
    exp_p = ref_posit(s, se, r, e, m, z, nr, exp_inex);

    @(negedge clk_i);
    out_ready_i = (hold == 0);
    sign_i = s; sign_exp_i = se; regime_i = 10'(r); exp_i = e; mant_i = m;
    zero_i = z; nar_i = nr; in_valid_i = 1'b1;
    check({tag, ":in_ready"}, in_ready_o, 1);

    @(posedge clk_i);
    @(negedge clk_i);
    // Scramble the inputs: they only have to be stable in the accept cycle.
    in_valid_i = 1'b0;
    sign_i = 1'($urandom); sign_exp_i = 1'($urandom); regime_i = 10'($urandom);
    exp_i = 2'($urandom); mant_i = {$urandom, $urandom};
    zero_i = 1'($urandom); nar_i = 1'($urandom);
    lat = 1;
    while (out_valid_o !== 1'b1 && lat < 10) begin
      check({tag, ":busy"}, in_ready_o, 0);
      @(posedge clk_i);
      @(negedge clk_i);
      lat++;
    end
    check({tag, ":latency"}, lat, 3);
    check({tag, ":posit"}, posit_o, exp_p);
`ifdef POSIT_ENC_INEXACT_EN
    check({tag, ":inexact"}, inexact_o, exp_inex);
`endif

    for (int k = 0; k < hold; k++) begin
      in_valid_i = 1'b1;
      regime_i = 10'd1; sign_i = ~s;
      @(posedge clk_i);
      @(negedge clk_i);
      in_valid_i = 1'b0;
      check({tag, ":hold_valid"}, out_valid_o, 1);
      check({tag, ":hold_ready"}, in_ready_o, 0);
      check({tag, ":hold_posit"}, posit_o, exp_p);
    end
    out_ready_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    check({tag, ":done_valid"}, out_valid_o, 0);
    check({tag, ":done_ready"}, in_ready_o, 1);
  endtask

  initial begin
    int seen;

    // Reset state
    #12;
    check("rst_in_ready", in_ready_o, 1);
    check("rst_out_valid", out_valid_o, 0);
    check("rst_posit", posit_o, 0);
    @(negedge clk_i);
    rst_i = 1'b0;

    // Basic values
    run_op("one",      0, 0, 1,  2'd0, 64'h8000_0000_0000_0000, 0, 0, 0);
    run_op("neg_one",  1, 0, 1,  2'd0, 64'h8000_0000_0000_0000, 0, 0, 0);
    run_op("two",      0, 0, 1,  2'd1, 64'h8000_0000_0000_0000, 0, 0, 0);
    run_op("one_half", 0, 0, 1,  2'd0, 64'hC000_0000_0000_0000, 0, 0, 0);
    // Rounding
    run_op("tie_even", 0, 0, 1,  2'd0, 64'h8000_0008_0000_0000, 0, 0, 0);
    run_op("tie_odd",  0, 0, 1,  2'd0, 64'h8000_0018_0000_0000, 0, 0, 0);
    run_op("above",    0, 0, 1,  2'd0, 64'h8000_0008_0000_0001, 0, 0, 0);
    run_op("neg_rgm",  1, 1, 3,  2'd2, 64'hA5A5_0000_1234_5678, 0, 0, 0);
    run_op("long_rgm", 0, 0, 30, 2'd3, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 0);
    run_op("minrgm",   0, 1, 30, 2'd3, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 0);
    // Saturation and specials
    run_op("sat_max",  0, 0, 40, 2'd3, 64'hFFFF_0000_0000_0000, 0, 0, 0);
    run_op("sat_min",  0, 1, 40, 2'd3, 64'hFFFF_0000_0000_0000, 0, 0, 0);
    run_op("sat_31",   1, 0, 31, 2'd0, 64'h8000_0000_0000_0000, 0, 0, 0);
    run_op("zero",     0, 0, 5,  2'd1, 64'h9000_0000_0000_0001, 1, 0, 0);
    run_op("nar",      1, 0, 5,  2'd1, 64'h9000_0000_0000_0001, 1, 1, 0);

    // Back-pressure: five held cycles with ignored in_valid_i pulses
    run_op("bp",       1, 0, 2,  2'd2, 64'hDEAD_BEEF_CAFE_F00D, 0, 0, 5);
    run_op("after_bp", 0, 0, 1,  2'd0, 64'h8000_0000_0000_0000, 0, 0, 0);

    // Asynchronous reset while in ROUND
    @(negedge clk_i);
    sign_i = 0; sign_exp_i = 0; regime_i = 10'd1; exp_i = 2'd1;
    mant_i = 64'h8000_0000_0000_0000; zero_i = 0; nar_i = 0; in_valid_i = 1'b1;
    @(posedge clk_i);            // accept -> PACK
    @(negedge clk_i);
    in_valid_i = 1'b0;
    @(posedge clk_i);            // -> ROUND
    #2 rst_i = 1'b1;
    #1;
    check("arst_out_valid", out_valid_o, 0);
    check("arst_in_ready", in_ready_o, 1);
    check("arst_posit", posit_o, 0);
    @(negedge clk_i);
    rst_i = 1'b0;
    seen = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk_i);
      if (out_valid_o === 1'b1) seen++;
    end
    check("arst_no_output", seen, 0);
    run_op("post_rst", 0, 0, 1,  2'd1, 64'h8000_0000_0000_0000, 0, 0, 0);

    // Random operations
    for (int t = 0; t < 150; t++) begin
      bit [63:0] m;
      bit        z, nr;
      int        r;
      m  = {1'b1, 31'($urandom), $urandom};
      if (($urandom % 4) == 0) m[34:0] = 35'd0;
      r  = ($urandom % 8 == 0) ? int'($urandom_range(31, 60)) : int'($urandom_range(1, 30));
      z  = ($urandom % 16 == 0);
      nr = ($urandom % 16 == 0);
      run_op($sformatf("rnd%0d", t), 1'($urandom), 1'($urandom), r, 2'($urandom),
             m, z, nr, ($urandom % 10 == 0) ? 2 : 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
